serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu.sv | 121 ++++++++++++
 tb/tb_serial_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// Bit-serial ALU: processes one operand bit per clock, LSB first, using the
// same 1-bit slice as the ripple ALU, and reports flags when it reaches DONE.
module serial_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluOp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_q, b_q, acc, acc_next, final_res;
   logic [2:0]       op_q;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;

   logic a_i, b_i, bx, and_t, or_t, nor_t, sum_t, c_next, sel_bit, set_v;

   // One slice of the ripple ALU, evaluated on bit[cnt] of the latched operands.
   always_comb begin
      a_i     = a_q[cnt];
      b_i     = b_q[cnt];
      bx      = b_i ^ op_q[2];
      and_t   = a_i & bx;
      or_t    = a_i | bx;
      nor_t   = ~(a_i | b_i);
      sum_t   = a_i ^ bx ^ carry;
      c_next  = and_t | (carry & (a_i ^ bx));
      last    = (cnt == CW'(WIDTH - 1));
      set_v   = (carry ^ c_next) ^ sum_t;
      sel_bit = 1'b0;
      case (op_q[1:0])
         2'b00:   sel_bit = and_t;
         2'b01:   sel_bit = op_q[2] ? nor_t : or_t;
         2'b10:   sel_bit = sum_t;
         default: sel_bit = 1'b0;
      endcase
      acc_next      = acc;
      acc_next[cnt] = sel_bit;
      final_res     = acc_next;
      // The set value only exists once the MSB slice has been evaluated.
      if (op_q[1:0] == 2'b11)
         final_res[0] = set_v;
   end

   // NOTE: a default for state_next first means every path assigns it, so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Operand latches and accumulator are not reset; they are reloaded on every start.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         result    <= '0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= aluOp;
                  carry <= aluOp[2];
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= c_next;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  result    <= final_res;
                  overflow  <= carry ^ c_next;
                  carry_out <= c_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign zero = ~|result;

endmodule

// File: tb/tb_serial_alu.sv
// Randomized self-checking bench for serial_alu against an arithmetic
// reference model, plus directed cases for flags, busy-start and reset.
module tb_serial_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a_in, b_in;
   logic [2:0]   op_in;
   logic         busy, done, zero, overflow, carry_out;
   logic [W-1:0] result;

   int n_vec = 0;
   int n_err = 0;

   serial_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a_in),
      .b         (b_in),
      .aluOp     (op_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic on the opcode's meaning.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, output logic [W-1:0] r,
                                 output logic ov, output logic co);
      logic [W-1:0] bx;
      logic [W:0]   s;
      logic [W-1:0] lo;
      logic         cin_msb, set_v;
      bx      = op[2] ? ~b : b;
      s       = {1'b0, a} + {1'b0, bx} + (W+1)'(op[2]);
      lo      = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + W'(op[2]);
      cin_msb = lo[W-1];
      co      = s[W];
      ov      = cin_msb ^ co;
      set_v   = ov ^ s[W-1];
      case (op[1:0])
         2'b00:   r = a & bx;
         2'b01:   r = op[2] ? ~(a | b) : (a | b);
         2'b10:   r = s[W-1:0];
         default: r = {{(W-1){1'b0}}, set_v};
      endcase
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input bit inject);
      logic [W-1:0] er;
      logic         eov, eco;
      int           cycles;
      model(a, b, op, er, eov, eco);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      op_in = op;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in  = $urandom;
      b_in  = $urandom;
      op_in = 3'($urandom);
      check("busy_run", busy, 1);
      cycles = 0;
      while (!done && cycles < 3 * W) begin
         @(negedge clk);
         cycles++;
         if (inject && cycles == 3) begin
            start = 1'b1;
            a_in  = $urandom;
            b_in  = $urandom;
            op_in = 3'b010;
         end
         if (inject && cycles == 5)
            start = 1'b0;
      end
      check("latency", 64'(cycles), 64'(W));
      check("result", result, er);
      check("zero", zero, (er == '0));
      check("overflow", overflow, eov);
      check("carry_out", carry_out, eco);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("hold", result, er);
   endtask

   initial begin
      logic [W-1:0] er;
      logic         eov, eco;
      int           dones;
      reset = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      op_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      check("rst_ovf", overflow, 0);
      check("rst_cout", carry_out, 0);

      run_op(32'd5, 32'd3, 3'b010, 0);
      run_op(32'h8000_0000, 32'd1, 3'b110, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 3'b111, 0);
      run_op(32'd0, 32'd0, 3'b101, 0);
      run_op(32'd7, 32'd7, 3'b110, 0);
      run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 0);
      run_op(32'hF0F0_1234, 32'h0FF0_0000, 3'b001, 0);
      run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b100, 0);
      run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b011, 0);
      run_op(32'h7FFF_FFFF, 32'd1, 3'b010, 0);

      // Second start during RUN: first operation must complete, one done pulse.
      run_op(32'd100, 32'd23, 3'b010, 1);
      dones = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("busy_start_no_extra_done", 64'(dones), 0);

      // Reset in RUN cycle 10 abandons the operation.
      run_op(32'd5, 32'd3, 3'b010, 0);
      @(negedge clk);
      a_in  = 32'd9;
      b_in  = 32'd4;
      op_in = 3'b010;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_result", result, 0);
      check("midrst_zero", zero, 1);
      dones = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", 64'(dones), 0);
      run_op(32'd9, 32'd4, 3'b110, 0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_prio_busy", busy, 0);
      check("rst_prio_result", result, 0);

      for (int i = 0; i < 40; i++)
         run_op($urandom, $urandom, 3'($urandom), 0);

      model(32'd1, 32'd2, 3'b111, er, eov, eco);
      run_op(32'd1, 32'd2, 3'b111, 0);
      check("slt_pos", result, er);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
